// File: rtl/dff_sreg_pkg.sv
// Shared types for the dff_sreg storage cell: the per-edge update decision and its priority.
package dff_sreg_pkg;

  typedef enum logic [1:0] {
    UPD_HOLD  = 2'd0,
    UPD_LOAD  = 2'd1,
    UPD_RESET = 2'd2
  } dff_upd_e;

  // Reset always wins over enable, so one function keeps the data flops and change flags in step.
  function automatic dff_upd_e dff_sreg_upd(input logic rst, input logic en);
    dff_upd_e upd;
    if (rst) begin
      upd = UPD_RESET;
    end else if (en) begin
      upd = UPD_LOAD;
    end else begin
      upd = UPD_HOLD;
    end
    return upd;
  endfunction

endpackage

// File: rtl/dff_sreg_bit.sv
// One-bit storage cell: synchronous active-high reset to RST_BIT, then load enable, else hold.
module dff_sreg_bit
  import dff_sreg_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    case (dff_sreg_upd(rst, en))
      UPD_RESET: q <= RST_BIT;
      UPD_LOAD:  q <= d;
      default:   q <= q;
    endcase
  end

endmodule

// File: rtl/dff_sreg.sv
// WIDTH-bit register with synchronous reset to RST_VAL and load enable.
// Optional DFF_SREG_CHANGE_EN adds o_chg: registered mask of the bits that toggled at the last edge.
module dff_sreg
  import dff_sreg_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
`ifdef DFF_SREG_CHANGE_EN
  ,
  output logic [WIDTH-1:0] o_chg
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_sreg_bit #(
      .RST_BIT (RST_VAL[i])
    ) u_bit (
      .clk (clk),
      .rst (i_rst),
      .en  (i_en),
      .d   (i_data[i]),
      .q   (o_data[i])
    );
  end

`ifdef DFF_SREG_CHANGE_EN
  // On a load the new value is i_data, so old ^ new is formed before the flops update.
  always_ff @(posedge clk) begin
    case (dff_sreg_upd(i_rst, i_en))
      UPD_LOAD: o_chg <= o_data ^ i_data;
      default:  o_chg <= '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_dff_sreg.sv
// Directed bench for dff_sreg: reset, glitch rejection, enable/hold, reset priority, random vs model,
// and the change mask when DFF_SREG_CHANGE_EN is defined.
module tb_dff_sreg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic       rst1 = 1'b0, en1 = 1'b0, d1 = 1'b0, q1;
  logic       rst8 = 1'b0, en8 = 1'b0;
  logic [7:0] d8 = '0, q8;
  logic       rstr = 1'b0, enr = 1'b0;
  logic [7:0] dr = '0, qr;
  logic       rst4 = 1'b0, en4 = 1'b0;
  logic [3:0] d4 = '0, q4;
`ifdef DFF_SREG_CHANGE_EN
  logic [3:0] chg4;
`endif

  dff_sreg #(.WIDTH(1), .RST_VAL(1'b0)) u_w1 (
    .clk(clk), .i_rst(rst1), .i_en(en1), .i_data(d1), .o_data(q1)
  );

  dff_sreg #(.WIDTH(8)) u_w8 (
    .clk(clk), .i_rst(rst8), .i_en(en8), .i_data(d8), .o_data(q8)
  );

  dff_sreg #(.WIDTH(8), .RST_VAL(8'h5A)) u_w8r (
    .clk(clk), .i_rst(rstr), .i_en(enr), .i_data(dr), .o_data(qr)
  );

  dff_sreg #(.WIDTH(4)) u_w4 (
    .clk(clk), .i_rst(rst4), .i_en(en4), .i_data(d4), .o_data(q4)
`ifdef DFF_SREG_CHANGE_EN
    , .o_chg(chg4)
`endif
  );

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; en1 = 1'b1; d1 = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick();
      total_cnt++;
      if (q1 !== 1'b0) $display("FAIL reset_hold edge%0d: got %b want 0", e, q1);
      else pass_cnt++;
    end
    rst1 = 1'b0;
    tick();
    total_cnt++;
    if (q1 !== 1'b1) $display("FAIL reset_release: got %b want 1", q1);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 3; c++) begin
      #1 rst1 = 1'b1;
      #2;
      total_cnt++;
      if (q1 !== 1'b1) $display("FAIL glitch_mid%0d: got %b want 1", c, q1);
      else pass_cnt++;
      #3 rst1 = 1'b0;
      tick();
      total_cnt++;
      if (q1 !== 1'b1) $display("FAIL glitch_edge%0d: got %b want 1", c, q1);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_hold();
    rst8 = 1'b1; en8 = 1'b0;
    tick();
    total_cnt++;
    if (q8 !== 8'h00) $display("FAIL en_reset: got %h want 00", q8);
    else pass_cnt++;
    rst8 = 1'b0; en8 = 1'b1; d8 = 8'hA5;
    tick();
    total_cnt++;
    if (q8 !== 8'hA5) $display("FAIL en_load: got %h want a5", q8);
    else pass_cnt++;
    en8 = 1'b0; d8 = 8'h3C;
    for (int e = 0; e < 3; e++) begin
      tick();
      total_cnt++;
      if (q8 !== 8'hA5) $display("FAIL en_hold%0d: got %h want a5", e, q8);
      else pass_cnt++;
    end
    en8 = 1'b1;
    tick();
    total_cnt++;
    if (q8 !== 8'h3C) $display("FAIL en_reload: got %h want 3c", q8);
    else pass_cnt++;
  endtask

  task automatic test_reset_priority();
    rstr = 1'b1; enr = 1'b1; dr = 8'hFF;
    tick();
    total_cnt++;
    if (qr !== 8'h5A) $display("FAIL prio_reset: got %h want 5a", qr);
    else pass_cnt++;
    rstr = 1'b0;
    tick();
    total_cnt++;
    if (qr !== 8'hFF) $display("FAIL prio_load: got %h want ff", qr);
    else pass_cnt++;
    rstr = 1'b1; enr = 1'b0;
    tick();
    total_cnt++;
    if (qr !== 8'h5A) $display("FAIL prio_reset_noen: got %h want 5a", qr);
    else pass_cnt++;
    rstr = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] model;
    rst8 = 1'b1; en8 = 1'b0;
    tick();
    model = 8'h00;
    total_cnt++;
    if (q8 !== model) $display("FAIL rand_init: got %h want %h", q8, model);
    else pass_cnt++;
    for (int c = 0; c < 20; c++) begin
      // Early reset pulse that is withdrawn before the edge must be ignored.
      #($urandom_range(1, 2));
      rst8 = 1'($urandom_range(0, 1));
      #($urandom_range(1, 2));
      d8 = 8'($urandom_range(0, 255));
      #($urandom_range(1, 2));
      rst8 = ($urandom_range(0, 3) == 0);
      en8  = 1'($urandom_range(0, 1));
      total_cnt++;
      if (q8 !== model) $display("FAIL rand_mid%0d: got %h want %h", c, q8, model);
      else pass_cnt++;
      if (rst8)     model = 8'h00;
      else if (en8) model = d8;
      tick();
      total_cnt++;
      if (q8 !== model) $display("FAIL rand_edge%0d: got %h want %h", c, q8, model);
      else pass_cnt++;
    end
    rst8 = 1'b0; en8 = 1'b0;
  endtask

`ifdef DFF_SREG_CHANGE_EN
  task automatic test_change();
    rst4 = 1'b1; en4 = 1'b0;
    tick();
    total_cnt++;
    if (q4 !== 4'b0000 || chg4 !== 4'b0000) $display("FAIL chg_reset0: got q=%b chg=%b want 0000/0000", q4, chg4);
    else pass_cnt++;
    rst4 = 1'b0; en4 = 1'b1; d4 = 4'b0011;
    tick();
    total_cnt++;
    if (q4 !== 4'b0011 || chg4 !== 4'b0011) $display("FAIL chg_load1: got q=%b chg=%b want 0011/0011", q4, chg4);
    else pass_cnt++;
    d4 = 4'b0101;
    tick();
    total_cnt++;
    if (q4 !== 4'b0101 || chg4 !== 4'b0110) $display("FAIL chg_load2: got q=%b chg=%b want 0101/0110", q4, chg4);
    else pass_cnt++;
    en4 = 1'b0; d4 = 4'b1111;
    tick();
    total_cnt++;
    if (q4 !== 4'b0101 || chg4 !== 4'b0000) $display("FAIL chg_hold: got q=%b chg=%b want 0101/0000", q4, chg4);
    else pass_cnt++;
    rst4 = 1'b1; en4 = 1'b1;
    tick();
    total_cnt++;
    if (q4 !== 4'b0000 || chg4 !== 4'b0000) $display("FAIL chg_reset: got q=%b chg=%b want 0000/0000", q4, chg4);
    else pass_cnt++;
    rst4 = 1'b0; en4 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_enable_hold();
    test_reset_priority();
    test_random();
`ifdef DFF_SREG_CHANGE_EN
    test_change();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dff_sreg.md
Name: dff_sreg

Overview:
- Parameterised D flip-flop register with synchronous, active-high reset and a load enable.
- It is the team's basic storage cell: pipeline stages, flag registers and sampled control bits instantiate it instead of hand-written always blocks.
- All state changes happen only on the rising edge of the single clock. A reset pulse that starts and ends between two edges is ignored by design.

Parameters:
- WIDTH, 1: data width in bits; legal range 1..64.
- RST_VAL, {WIDTH{1'b0}}: value loaded into o_data on reset; WIDTH bits wide.

Ports:
- clk  input  1  single clock; all flops trigger on the rising edge.
- i_rst  input  1  synchronous, active-high reset, sampled only at the rising edge of clk.
- i_en  input  1  load enable, active-high.
- i_data  input  WIDTH  data to be captured.
- o_data  output  WIDTH  registered data, driven directly from flops with no combinational path from inputs.

Behaviour:
- Clock/reset (already decided): one clock, clk; reset i_rst is synchronous and active-high. No asynchronous set or reset path of any kind.
- Priority at each rising edge of clk:
  - i_rst=1 -> o_data <= RST_VAL.
  - else i_en=1 -> o_data <= i_data.
  - else o_data holds its value.
- Reset dominates enable: i_rst=1 with i_en=1 loads RST_VAL, not i_data.
- Latency: exactly 1 clock from i_data or i_rst sampled to o_data update. o_data changes only at rising edges and never between them, whatever i_rst or i_data do.
- Reset timing: assertion or deassertion between edges has no effect until the next edge samples it.
  - A reset pulse that does not cover a rising edge is lost.
  - Reset held for N edges keeps o_data at RST_VAL for those N edges.
  - The first load after reset happens at the first edge that samples i_rst=0 and i_en=1.
- Power-up: o_data is X until the first edge that samples i_rst=1 or i_en=1. The bench must assert reset for at least one edge before checking.
- Setup/hold: inputs must be stable around the rising edge; no metastability handling. Asynchronous inputs must first pass through a synchroniser.
- Width rules: i_data and o_data are exactly WIDTH bits, with no truncation or extension inside the block. RST_VAL is truncated/zero-extended to WIDTH at elaboration.

Optional Feature:
- Macro: DFF_SREG_CHANGE_EN.
- When defined, the block adds output o_chg (WIDTH bits, registered).
  - At each edge, o_chg <= bitwise XOR of the old o_data and the new o_data, i.e. the bits that toggled at that edge.
  - On a reset edge, o_chg <= 0.
  - When i_en=0 and i_rst=0, o_chg <= 0.
- When undefined, o_chg and its flops do not exist; the port list is exactly as above.

Decomposition:
- No shared package is required.
- A one-bit cell sub-module, dff_sreg_bit, is natural. It holds one flop with rst/en/d and its reset value bit. The top instantiates WIDTH copies via generate and slices RST_VAL per bit.
- The change-detect logic lives in the top under the macro.

Test Plan:
- Reset sample: WIDTH=1, RST_VAL=0, clk 10 ns period.
  - Hold i_rst=1 across 2 edges with i_data=1, i_en=1 -> o_data=0 after the first edge and stays 0.
  - Release reset -> o_data=1 after the next edge.
- Mid-cycle reset glitch: o_data=1.
  - Pulse i_rst=1 from 2 ns to 7 ns after an edge, not covering the next edge -> o_data stays 1 at every edge.
- Enable/hold: WIDTH=8.
  - Load 8'hA5 with i_en=1.
  - Set i_en=0 and drive 8'h3C for 3 edges -> o_data stays 8'hA5.
  - Set i_en=1 -> 8'h3C after 1 edge.
- Reset priority and non-zero RST_VAL: WIDTH=8, RST_VAL=8'h5A.
  - i_rst=1, i_en=1, i_data=8'hFF -> o_data=8'h5A.
  - Next edge with i_rst=0 -> 8'hFF.
- Random stimulus: i_data and i_rst change at random offsets within each 10 ns period for 10+ cycles.
  - o_data must match a reference model sampled only at rising edges, with zero mismatches.
- With DFF_SREG_CHANGE_EN: WIDTH=4.
  - Load 4'b0011 then 4'b0101 -> o_chg=4'b0110 after the second load.
  - Reset edge -> o_chg=4'b0000.
